// File: rtl/sine_pkg.sv
// ----------------------------------------------------------------------------
// sine_pkg
// Shared constants and types for the quarter-wave sine ROM and the
// successive-approximation arcsine engine.
//   X_W / Y_W        phase and sample widths (fixed at 10 / 8)
//   ROM_AW / ROM_DW  quarter-wave table address / data widths
//   MID              offset-binary midpoint of a sample
//   state_t          arcsine engine FSM states
//   QUAD_*           quadrant codes forming the top two phase bits
//   map_phase()      folds a quarter-wave index into a full-circle phase
// ----------------------------------------------------------------------------
package sine_pkg;

    localparam int X_W       = 10;
    localparam int Y_W       = 8;
    localparam int ROM_AW    = 8;
    localparam int ROM_DW    = 7;
    localparam int ROM_DEPTH = 256;

    localparam logic [Y_W-1:0] MID = 8'd128;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_CMP   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [1:0] QUAD_0 = 2'b00;
    localparam logic [1:0] QUAD_1 = 2'b01;
    localparam logic [1:0] QUAD_2 = 2'b10;
    localparam logic [1:0] QUAD_3 = 2'b11;

    // Positive half uses quadrants 0/1, negative half 2/3. Quadrants 1 and 3
    // run the table backwards, so the index is mirrored (255-L == ~L).
    function automatic logic [X_W-1:0] map_phase(input logic neg,
                                                 input logic branch,
                                                 input logic [ROM_AW-1:0] l);
        logic [X_W-1:0] r;
        case ({neg, branch})
            2'b00:   r = {QUAD_0, l};
            2'b01:   r = {QUAD_1, ~l};
            2'b11:   r = {QUAD_2, l};
            default: r = {QUAD_3, ~l};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/sine_qrom.sv
// ----------------------------------------------------------------------------
// sine_qrom
// Synchronous quarter-wave sine table: dout = round(127*sin(pi/2*addr/256)),
// registered one cycle after addr. The contents are generated at elaboration
// by a fixed-point Taylor series (Q30), accurate far below the rounding step.
// Ports:
//   clk   in   rising-edge clock
//   addr  in   [7:0] table index
//   dout  out  [6:0] table value for the addr of the previous cycle
// ----------------------------------------------------------------------------
module sine_qrom
    import sine_pkg::*;
(
    input  logic              clk,
    input  logic [ROM_AW-1:0] addr,
    output logic [ROM_DW-1:0] dout
);

    localparam longint HALF_PI_Q30 = 64'sd1686629713;

    function automatic logic [ROM_DW*ROM_DEPTH-1:0] build_table();
        logic [ROM_DW*ROM_DEPTH-1:0] tbl;
        longint ang;
        longint ang2;
        longint term;
        longint acc;
        longint v;
        tbl = '0;
        for (int a = 0; a < ROM_DEPTH; a++) begin
            ang  = (HALF_PI_Q30 * a) / 256;
            ang2 = (ang * ang) >>> 30;
            term = ang;
            acc  = ang;
            // sin(x) = x - x^3/3! + x^5/5! - ... ; eight extra terms suffice below pi/2
            for (int k = 1; k <= 8; k++) begin
                term = -((term * ang2) >>> 30) / ((2 * k) * (2 * k + 1));
                acc  = acc + term;
            end
            v = (acc * 127 + (64'sd1 <<< 29)) >>> 30;
            tbl[a*ROM_DW +: ROM_DW] = v[ROM_DW-1:0];
        end
        return tbl;
    endfunction

    localparam logic [ROM_DW*ROM_DEPTH-1:0] ROM_TBL = build_table();

    always_ff @(posedge clk) begin
        dout <= ROM_TBL[int'(addr)*ROM_DW +: ROM_DW];
    end

endmodule

// File: rtl/sine_arcsin_sar.sv
// ----------------------------------------------------------------------------
// sine_arcsin_sar
// Inverse sine: recovers a 10-bit phase x from an 8-bit offset-binary sample
// y by an 8-step successive-approximation search over the quarter-wave ROM.
// Each bit takes two cycles (ISSUE drives the ROM address, CMP consumes the
// registered data), so a result appears 17 cycles after the accepted start.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   start        request, sampled only while idle
//   y            sample, captured with an accepted start
//   branch       0: quadrant 0/3 solution, 1: quadrant 1/2 solution
//   busy         high from the cycle after start through the done cycle
//   done         one-cycle pulse, x valid
//   x            recovered phase, held until the next done
//   sat          present only when ARCSINE_SAT_FLAG_EN is defined:
//                captured y was 0 (magnitude clamped), valid with done
// Build option: `define ARCSINE_SAT_FLAG_EN to add the sat port.
// ----------------------------------------------------------------------------
module sine_arcsin_sar
    import sine_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [Y_W-1:0] y,
    input  logic           branch,
    output logic           busy,
    output logic           done,
    output logic [X_W-1:0] x
`ifdef ARCSINE_SAT_FLAG_EN
    ,
    output logic           sat
`endif
);

    state_t              r_state;
    logic [2:0]          r_bit;
    logic [ROM_AW-1:0]   r_l;
    logic [ROM_DW-1:0]   r_mag;
    logic                r_neg;
    logic                r_branch;
    logic                r_busy;
    logic                r_done;
    logic [X_W-1:0]      r_x;
`ifdef ARCSINE_SAT_FLAG_EN
    logic                r_yzero;
    logic                r_sat;
`endif

    logic                w_neg;
    logic [Y_W-1:0]      w_mag_raw;
    logic [ROM_DW-1:0]   w_mag;
    logic [ROM_AW-1:0]   w_t;
    logic [ROM_AW-1:0]   w_addr;
    logic [ROM_DW-1:0]   w_rom;
    logic [ROM_AW-1:0]   w_l_next;

    // Magnitude of the offset-binary sample; only y==0 reaches 128 and is
    // clamped to the table maximum.
    assign w_neg     = (y < MID);
    assign w_mag_raw = w_neg ? (MID - y) : (y - MID);
    assign w_mag     = (w_mag_raw == MID) ? {ROM_DW{1'b1}} : w_mag_raw[ROM_DW-1:0];

    // Trial index for the current bit; the ROM is probed at t-1 so the search
    // converges on the smallest index whose value reaches mag.
    assign w_t      = r_l | (ROM_AW'(1) << r_bit);
    assign w_addr   = w_t - ROM_AW'(1);
    assign w_l_next = (w_rom < r_mag) ? w_t : r_l;

    sine_qrom u_qrom (
        .clk  (clk),
        .addr (w_addr),
        .dout (w_rom)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_bit    <= '0;
            r_l      <= '0;
            r_mag    <= '0;
            r_neg    <= 1'b0;
            r_branch <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_x      <= '0;
`ifdef ARCSINE_SAT_FLAG_EN
            r_yzero  <= 1'b0;
            r_sat    <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_neg    <= w_neg;
                        r_mag    <= w_mag;
                        r_branch <= branch;
                        r_l      <= '0;
                        r_bit    <= 3'd7;
                        r_busy   <= 1'b1;
`ifdef ARCSINE_SAT_FLAG_EN
                        r_yzero  <= (y == '0);
`endif
                        r_state  <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_state <= S_CMP;
                end
                S_CMP: begin
                    r_l <= w_l_next;
                    if (r_bit == 3'd0) begin
                        r_done  <= 1'b1;
                        r_x     <= map_phase(r_neg, r_branch, w_l_next);
`ifdef ARCSINE_SAT_FLAG_EN
                        r_sat   <= r_yzero;
`endif
                        r_state <= S_DONE;
                    end else begin
                        r_bit   <= r_bit - 3'd1;
                        r_state <= S_ISSUE;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign x    = r_x;
`ifdef ARCSINE_SAT_FLAG_EN
    assign sat  = r_sat;
`endif

endmodule

// File: tb/tb_sine_arcsin_sar.sv
// ----------------------------------------------------------------------------
// tb_sine_arcsin_sar
// Bench for the arcsine engine. The reference computes the sine table with
// real arithmetic, finds the lower-bound index by linear search and maps it
// to the phase quadrant; a sine-generator model closes the loopback.
// ----------------------------------------------------------------------------
module tb_sine_arcsin_sar;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] y;
    logic       branch;
    logic       busy;
    logic       done;
    logic [9:0] x;
`ifdef ARCSINE_SAT_FLAG_EN
    logic       sat;
`endif

    int n_total = 0;
    int n_fail  = 0;
    int rom_tab [256];

    sine_arcsin_sar dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .y      (y),
        .branch (branch),
        .busy   (busy),
        .done   (done),
        .x      (x)
`ifdef ARCSINE_SAT_FLAG_EN
        ,
        .sat    (sat)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int lower_bound(input int mag);
        for (int a = 0; a < 256; a++)
            if (rom_tab[a] >= mag) return a;
        return 255;
    endfunction

    function automatic int exp_x(input int yv, input int bv);
        int mag;
        int l;
        bit neg;
        neg = (yv < 128);
        mag = neg ? 128 - yv : yv - 128;
        if (mag > 127) mag = 127;
        l = lower_bound(mag);
        if (!neg && bv == 0) return l;
        if (!neg && bv == 1) return 256 + 255 - l;
        if (neg && bv == 1)  return 512 + l;
        return 768 + 255 - l;
    endfunction

    function automatic int sine_gen(input int xv);
        int q;
        int a;
        q = xv / 256;
        a = xv % 256;
        case (q)
            0:       return 128 + rom_tab[a];
            1:       return 128 + rom_tab[255 - a];
            2:       return 128 - rom_tab[a];
            default: return 128 - rom_tab[255 - a];
        endcase
    endfunction

    // Entered and left at #1 after a rising edge in an idle cycle.
    task automatic run_conv(input logic [7:0] yv, input logic bv, input bit pulse,
                            output logic [9:0] xo);
        int cyc;
        int busy_cnt;
        y      = yv;
        branch = bv;
        start  = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        y      = 8'($urandom);
        branch = 1'($urandom);
        busy_cnt = 0;
        for (cyc = 1; cyc <= 24; cyc++) begin
            if (busy) busy_cnt++;
            if (done) break;
            start = pulse && (cyc == 5);
            @(posedge clk); #1;
        end
        chk("latency", 32'(cyc), 32'd17);
        chk("busy_cycles", 32'(busy_cnt), 32'd17);
        chk("x", 32'(x), 32'(exp_x(int'(yv), int'(bv))));
`ifdef ARCSINE_SAT_FLAG_EN
        chk("sat", 32'(sat), 32'(yv == 8'd0));
`endif
        xo    = x;
        start = pulse;
        @(posedge clk); #1;
        start = 1'b0;
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_done", 32'(done), 32'd0);
        chk("x_held", 32'(x), 32'(xo));
    endtask

    initial begin
        logic [9:0] xo;
        int base;
        int dcnt;

        for (int a = 0; a < 256; a++)
            rom_tab[a] = int'($floor(127.0 * $sin(3.141592653589793 / 2.0 * real'(a) / 256.0) + 0.5));

        rst_n  = 1'b0;
        start  = 1'b0;
        y      = 8'd0;
        branch = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_x", 32'(x), 32'd0);
`ifdef ARCSINE_SAT_FLAG_EN
        chk("rst_sat", 32'(sat), 32'd0);
`endif
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed values
        run_conv(8'd128, 1'b0, 1'b0, xo); chk("y128_b0", 32'(xo), 32'h000);
        run_conv(8'd128, 1'b1, 1'b0, xo); chk("y128_b1", 32'(xo), 32'h1FF);
        run_conv(8'd218, 1'b0, 1'b0, xo); chk("y218_b0", 32'(xo), 32'h080);
        run_conv(8'd218, 1'b1, 1'b0, xo); chk("y218_b1", 32'(xo), 32'h17F);
        run_conv(8'd38,  1'b1, 1'b0, xo); chk("y38_b1",  32'(xo), 32'h280);
        run_conv(8'd38,  1'b0, 1'b0, xo); chk("y38_b0",  32'(xo), 32'h37F);
        run_conv(8'd255, 1'b0, 1'b0, xo); chk("y255_b0", 32'(xo), 32'h0F2);
        run_conv(8'd0,   1'b0, 1'b0, xo); chk("y0_b0",   32'(xo), 32'h30D);
        run_conv(8'd1,   1'b0, 1'b0, xo);

        // Start pulses while busy and on the done cycle are ignored; the
        // following conversion starts in the first idle cycle.
        run_conv(8'd200, 1'b1, 1'b1, xo);
        run_conv(8'd60,  1'b0, 1'b1, xo);
        run_conv(8'd129, 1'b1, 1'b0, xo);

        // Loopback over every sample and both branches, random start offset
        base = int'($urandom_range(0, 255));
        for (int bv = 0; bv < 2; bv++) begin
            for (int i = 0; i < 256; i++) begin
                int yv;
                yv = (base + i) % 256;
                run_conv(8'(yv), 1'(bv), 1'b0, xo);
                chk("loopback", 32'(sine_gen(int'(xo))), 32'((yv == 0) ? 1 : yv));
            end
        end

        // Random conversions with random ignored start pulses
        for (int i = 0; i < 30; i++) begin
            run_conv(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), xo);
        end

        // Reset in the middle of a conversion
        y      = 8'd200;
        branch = 1'b0;
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("pre_abort_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_x", 32'(x), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        dcnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (done) dcnt++;
        end
        chk("no_done_after_abort", 32'(dcnt), 32'd0);
        run_conv(8'd218, 1'b0, 1'b0, xo); chk("after_abort", 32'(xo), 32'h080);

        $display("%0d/%0d checks passed", n_total - n_fail, n_total);
        $finish;
    end

endmodule
